// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: slices an ADC sample stream into FFT frames
// and buffers the extended samples behind a valid/ready stream port.
module fft_frame_feeder #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 32,
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int SIGNED     = 0
) (
    input  logic              fft_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              start,
    input  logic [DATA_W-1:0] ad_data_in,
    input  logic              ad_valid,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [OUT_W-1:0]  m_tdata,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       frame_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      frames_q, frames_d;
    logic [OUT_W:0]   mem_q [FIFO_DEPTH];

    logic [OUT_W-1:0] ext_data;
    logic [OUT_W:0]   head;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             wr_last;

    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign pop     = !rst && !empty && m_tready;
    assign wr_last = (idx_q == IDX_LAST);

    // Widen the sample: zero fill, or replicate the sign bit when SIGNED.
    always_comb begin
        ext_data = '0;
        if (SIGNED != 0 && ad_data_in[DATA_W-1]) begin
            ext_data = '1;
        end
        ext_data[DATA_W-1:0] = ad_data_in;
    end

    // Framing FSM, sample index, overflow flag and frame counter.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        frames_d = frames_q;
        push     = 1'b0;
        if (pop && head[OUT_W]) begin
            frames_d = frames_q + 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (en && (!mode || start)) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            FILL: begin
                if (en && ad_valid) begin
                    if (full && !pop) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (wr_last) begin
                            idx_d = '0;
                            if (mode) begin
                                state_d = DRAIN;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (pop && head[OUT_W]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    // FIFO pointer bookkeeping; dropping en flushes the buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge fft_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            frames_q <= frames_d;
        end
    end

    // Buffer storage; an entry carries {last, extended sample}.
    always_ff @(posedge fft_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_last, ext_data};
        end
    end

    assign m_tvalid   = !rst && !empty;
    assign m_tdata    = m_tvalid ? head[OUT_W-1:0] : '0;
    assign m_tlast    = m_tvalid && head[OUT_W];
    assign busy       = !rst && (state_q != IDLE);
    assign frame_done = pop && head[OUT_W];
    assign overflow   = !rst && ovf_q;
    assign frame_cnt  = rst ? 16'd0 : frames_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: scoreboard bench for fft_frame_feeder,
// one zero-extending and one sign-extending instance on shared stimulus.
module tb_fft_frame_feeder;

    localparam int L = 8;
    localparam int D = 16;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } ent_t;

    typedef enum { P_IDLE, P_FILL, P_DRAIN } ph_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic        mode     = 1'b0;
    logic        start    = 1'b0;
    logic        ad_valid = 1'b0;
    logic        m_tready = 1'b0;
    logic [7:0]  ad_data  = 8'h00;

    logic        tv0, tl0, bz0, fd0, ov0;
    logic [31:0] td0;
    logic [15:0] fc0;
    logic        tv1, tl1, bz1, fd1, ov1;
    logic [31:0] td1;
    logic [15:0] fc1;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    int   occ        = 0;
    int   idx        = 0;
    int   exp_frames = 0;
    int   beats      = 0;
    ph_t  ph         = P_IDLE;
    bit   m_ovf      = 1'b0;
    bit   hs_last    = 1'b0;

    fft_frame_feeder #(
        .DATA_W(8), .OUT_W(32), .FRAME_LEN(L),
        .FIFO_DEPTH(D), .SIGNED(0)
    ) u_zext (
        .fft_clk(clk), .rst(rst), .en(en), .mode(mode),
        .start(start), .ad_data_in(ad_data), .ad_valid(ad_valid),
        .m_tvalid(tv0), .m_tready(m_tready), .m_tdata(td0),
        .m_tlast(tl0), .busy(bz0), .frame_done(fd0),
        .overflow(ov0), .frame_cnt(fc0)
    );

    fft_frame_feeder #(
        .DATA_W(8), .OUT_W(32), .FRAME_LEN(L),
        .FIFO_DEPTH(D), .SIGNED(1)
    ) u_sext (
        .fft_clk(clk), .rst(rst), .en(en), .mode(mode),
        .start(start), .ad_data_in(ad_data), .ad_valid(ad_valid),
        .m_tvalid(tv1), .m_tready(m_tready), .m_tdata(td1),
        .m_tlast(tl1), .busy(bz1), .frame_done(fd1),
        .overflow(ov1), .frame_cnt(fc1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] zext(input logic [7:0] d);
        return 32'(d);
    endfunction

    function automatic logic [31:0] sext(input logic [7:0] d);
        return (d >= 8'd128) ? 32'hFFFFFF00 + 32'(d) : 32'(d);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: one step per clock edge, from the framing rules.
    task automatic model_step();
        bit   pop;
        bit   full;
        ent_t e;
        pop = !rst && m_tready && occ > 0;
        if (rst || !en) begin
            q.delete();
            occ = 0;
            idx = 0;
            ph  = P_IDLE;
            if (rst) m_ovf = 1'b0;
            return;
        end
        full = (occ == D);
        if (pop) occ--;
        case (ph)
            P_IDLE: begin
                if (!mode || start) begin
                    ph  = P_FILL;
                    idx = 0;
                end
            end
            P_FILL: begin
                if (ad_valid) begin
                    if (full && !pop) begin
                        m_ovf = 1'b1;
                    end else begin
                        e.d    = ad_data;
                        e.last = (idx == L - 1);
                        q.push_back(e);
                        occ++;
                        if (idx == L - 1) begin
                            idx = 0;
                            if (mode) ph = P_DRAIN;
                        end else begin
                            idx++;
                        end
                    end
                end
            end
            P_DRAIN: begin
                if (pop && hs_last) ph = P_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ad_valid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 64 && occ > 0; i++) tick();
        chk("drain_empty", tv0, 0);
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < L; i++) begin
            ad_valid = 1'b1;
            ad_data  = 8'(base + i);
            tick();
        end
        ad_valid = 1'b0;
    endtask

    // Monitor: compares presented beats and status against the model.
    initial begin
        ent_t e;
        bit   ev;
        bit   hs;
        forever begin
            @(negedge clk);
            ev     = !rst && q.size() > 0;
            hs     = ev && m_tready;
            e.d    = '0;
            e.last = 1'b0;
            if (ev) e = q[0];
            chk("tvalid", tv0, ev);
            chk("tvalid_s", tv1, ev);
            if (ev) begin
                chk("tdata", td0, zext(e.d));
                chk("tdata_s", td1, sext(e.d));
                chk("tlast", tl0, e.last);
                chk("tlast_s", tl1, e.last);
            end
            if (rst) begin
                chk("rst_tdata", td0, 0);
                chk("rst_tlast", tl0, 0);
            end
            chk("frame_done", fd0, hs && e.last);
            chk("frame_done_s", fd1, hs && e.last);
            chk("frame_cnt", fc0, rst ? 16'd0 : 16'(exp_frames));
            chk("overflow", ov0, !rst && m_ovf);
            chk("busy", bz0, !rst && ph != P_IDLE);
            chk("busy_s", bz1, !rst && ph != P_IDLE);
            hs_last = 1'b0;
            if (rst) exp_frames = 0;
            if (hs) begin
                void'(q.pop_front());
                beats++;
                if (e.last) begin
                    hs_last = 1'b1;
                    exp_frames++;
                end
            end
        end
    end

    // Stimulus: directed scenarios, then a randomized soak.
    initial begin
        int n;
        int b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_tvalid", tv0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_cnt", fc0, 0);
        chk("rst_ovf", ov0, 0);
        rst = 1'b0;
        tick();
        chk("rel_busy", bz0, 0);
        chk("rel_tvalid", tv0, 0);

        en       = 1'b1;
        mode     = 1'b1;
        start    = 1'b1;
        m_tready = 1'b1;
        tick();
        start = 1'b0;
        chk("ss_busy", bz0, 1);
        send_frame(0);
        drain();
        chk("ss_cnt", fc0, 1);
        chk("ss_busy_end", bz0, 0);

        mode = 1'b0;
        tick();
        n = 0;
        for (int k = 0; k < 400 && n < 24; k++) begin
            ad_valid = ($urandom_range(0, 3) != 0);
            ad_data  = 8'($urandom);
            tick();
            if (ad_valid) n++;
        end
        drain();
        chk("cont_cnt", fc0, 4);
        en = 1'b0;
        tick();
        chk("cont_stop_busy", bz0, 0);

        en       = 1'b1;
        mode     = 1'b0;
        m_tready = 1'b0;
        tick();
        ad_valid = 1'b1;
        ad_data  = 8'h80;
        tick();
        chk("zext_80", td0, 32'h00000080);
        chk("sext_80", td1, 32'hFFFFFF80);
        for (int i = 1; i < 20; i++) begin
            ad_data = 8'($urandom);
            tick();
        end
        ad_valid = 1'b0;
        chk("bp_ovf", ov0, 1);
        chk("bp_head_hold", td0, 32'h00000080);
        b0       = beats;
        ad_valid = 1'b1;
        ad_data  = 8'h5A;
        m_tready = 1'b1;
        tick();
        ad_valid = 1'b0;
        m_tready = 1'b0;
        tick();
        chk("bp_ovf_sticky", ov0, 1);
        drain();
        chk("bp_beats", beats - b0, 17);
        chk("bp_cnt", fc0, 6);
        en = 1'b0;
        tick();

        en       = 1'b1;
        mode     = 1'b1;
        start    = 1'b1;
        m_tready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ad_valid = 1'b1;
            ad_data  = 8'(i + 16);
            tick();
        end
        ad_valid = 1'b0;
        en       = 1'b0;
        tick();
        chk("abort_tvalid", tv0, 0);
        chk("abort_busy", bz0, 0);
        chk("abort_cnt", fc0, 6);
        chk("abort_ovf", ov0, 1);

        en       = 1'b1;
        start    = 1'b1;
        m_tready = 1'b1;
        tick();
        start = 1'b0;
        send_frame(40);
        drain();
        chk("restart_cnt", fc0, 7);

        start    = 1'b1;
        m_tready = 1'b0;
        tick();
        start = 1'b0;
        send_frame(100);
        tick();
        chk("drain_busy", bz0, 1);
        rst = 1'b1;
        tick();
        chk("midrst_cnt", fc0, 0);
        chk("midrst_tvalid", tv0, 0);
        chk("midrst_ovf", ov0, 0);
        chk("midrst_busy", bz0, 0);
        rst = 1'b0;
        tick();
        chk("midrst_rel_tvalid", tv0, 0);
        chk("midrst_rel_ovf", ov0, 0);
        start    = 1'b1;
        m_tready = 1'b1;
        tick();
        start = 1'b0;
        send_frame(200);
        drain();
        chk("midrst_next_cnt", fc0, 1);

        for (int k = 0; k < 600; k++) begin
            if (ph == P_IDLE && $urandom_range(0, 3) == 0)
                mode = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 24) != 0);
            start    = ($urandom_range(0, 3) == 0);
            ad_valid = ($urandom_range(0, 2) != 0);
            ad_data  = 8'($urandom);
            m_tready = ($urandom_range(0, 9) < 6);
            tick();
        end
        en    = 1'b1;
        start = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
